alustage3: RTL

- Execute stage directly downstream of registersstage2.
- Consumes registersstage2's outbound instruction word.
- Reads two source registers through register-file read ports and performs the ALU operation.
- Returns the result to the register file through a registered write port, updates condition flags, and forwards the instruction word to the next stage.
- Shifts and multiplies are iterative and stall upstream while running.

---
 rtl/alustage3_pkg.sv | 47 ++++
 rtl/alustage3_alu.sv | 45 ++++
 rtl/alustage3.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alustage3_pkg.sv
// alustage3_pkg: shared types, opcode constants and field positions for the execute stage
package alustage3_pkg;

    typedef logic [31:0] t_reg;
    typedef logic [3:0]  t_reg_index;

    typedef enum logic [5:0] {
        OP_NOP = 6'h00,
        OP_ADD = 6'h10,
        OP_SUB = 6'h11,
        OP_AND = 6'h12,
        OP_OR  = 6'h13,
        OP_XOR = 6'h14,
        OP_SHL = 6'h15,
        OP_SHR = 6'h16,
        OP_ASR = 6'h17,
        OP_MUL = 6'h18
    } t_alu_op;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } t_alu_flags;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int DEST_HI   = 25;
    localparam int DEST_LO   = 22;
    localparam int LEFT_HI   = 21;
    localparam int LEFT_LO   = 18;
    localparam int RIGHT_HI  = 17;
    localparam int RIGHT_LO  = 14;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL
    } t_alu_state;

    // N and Z always follow the result; C and V are op-specific
    function automatic t_alu_flags result_flags(input t_reg r, input logic c, input logic v);
        return '{c: c, v: v, n: r[31], z: r == '0};
    endfunction

endpackage

// File: rtl/alustage3_alu.sv
// alustage3_alu: combinational single-cycle ALU (add/sub/logic; shifts by zero pass left through)
module alustage3_alu
    import alustage3_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] left,
    input  logic [31:0] right,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic        c;
    logic        v;

    assign sum  = {1'b0, left} + {1'b0, right};
    assign diff = {1'b0, left} - {1'b0, right};

    // select the result and the op-specific carry/overflow; diff[32] is the unsigned borrow
    always_comb begin
        result = left;
        c      = 1'b0;
        v      = 1'b0;
        case (t_alu_op'(op))
            OP_ADD: begin
                result = sum[31:0];
                c      = sum[32];
                v      = (left[31] == right[31]) && (sum[31] != left[31]);
            end
            OP_SUB: begin
                result = diff[31:0];
                c      = diff[32];
                v      = (left[31] != right[31]) && (diff[31] != left[31]);
            end
            OP_AND:  result = left & right;
            OP_OR:   result = left | right;
            OP_XOR:  result = left ^ right;
            default: result = left;
        endcase
    end

    assign flags = result_flags(result, c, v);

endmodule

// File: rtl/alustage3.sv
// alustage3: execute stage with single-cycle ALU ops and iterative shift / shift-add multiply
module alustage3
    import alustage3_pkg::*;
#(
    parameter int MUL_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inbound_instruction,
    output logic [3:0]  reg_left_index,
    output logic [3:0]  reg_right_index,
    input  logic [31:0] reg_left_data,
    input  logic [31:0] reg_right_data,
    output logic [3:0]  write_index,
    output logic        write,
    output logic [31:0] write_data,
    output logic        stall,
    output logic [3:0]  flags,
    output logic [31:0] outbound_instruction
);

    t_alu_state state;
    t_alu_state next_state;
    t_alu_op    op;
    t_alu_op    lat_op;
    logic [5:0] cnt;
    logic [5:0] cnt_d;
    t_reg       acc;
    t_reg       acc_d;
    t_reg       mcand;
    t_reg       mcand_d;
    t_reg       mplier;
    t_reg       mplier_d;
    t_reg       lat_instr;
    t_reg       lat_instr_d;
    t_reg_index lat_dest;
    t_reg_index lat_dest_d;
    logic       write_d;
    t_reg_index write_index_d;
    t_reg       write_data_d;
    logic [3:0] flags_d;
    t_reg       outbound_d;
    t_reg       alu_result;
    logic [3:0] alu_flags;
    logic       is_alu;
    logic       is_shift;
    logic       is_mul;
    logic       zero_count;
    logic       last;
    t_reg       shift_next;
    logic       shift_c;
    t_reg       mul_next;

    assign op              = t_alu_op'(inbound_instruction[OPCODE_HI:OPCODE_LO]);
    assign lat_op          = t_alu_op'(lat_instr[OPCODE_HI:OPCODE_LO]);
    assign reg_left_index  = inbound_instruction[LEFT_HI:LEFT_LO];
    assign reg_right_index = inbound_instruction[RIGHT_HI:RIGHT_LO];
    assign is_alu          = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    assign is_shift        = op inside {OP_SHL, OP_SHR, OP_ASR};
    assign is_mul          = MUL_ENABLE != 0 && op == OP_MUL;
    assign zero_count      = reg_right_data[4:0] == 5'd0;
    assign stall           = state != IDLE;
    assign last            = cnt == 6'd1;
    assign shift_next      = lat_op == OP_SHL ? {acc[30:0], 1'b0} : {lat_op == OP_ASR && acc[31], acc[31:1]};
    assign shift_c         = lat_op == OP_SHL ? acc[31] : acc[0];
    assign mul_next        = acc + (mplier[0] ? mcand : '0);

    alustage3_alu u_alu (
        .op     (inbound_instruction[OPCODE_HI:OPCODE_LO]),
        .left   (reg_left_data),
        .right  (reg_right_data),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // state register; reset abandons any iterative op in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // iterative ops leave IDLE; they return on the step that consumes the last count
    always_comb begin
        next_state = state == IDLE ? (is_shift && !zero_count ? SHIFT : is_mul ? MUL : IDLE)
                                   : (last ? IDLE : state);
    end

    // next values for the datapath and the registered outputs
    always_comb begin
        cnt_d         = cnt;
        acc_d         = acc;
        mcand_d       = mcand;
        mplier_d      = mplier;
        lat_instr_d   = lat_instr;
        lat_dest_d    = lat_dest;
        write_d       = 1'b0;
        write_index_d = write_index;
        write_data_d  = write_data;
        flags_d       = flags;
        outbound_d    = '0;
        case (state)
            IDLE: begin
                if (is_alu || (is_shift && zero_count)) begin
                    write_d       = 1'b1;
                    write_index_d = inbound_instruction[DEST_HI:DEST_LO];
                    write_data_d  = alu_result;
                    flags_d       = alu_flags;
                    outbound_d    = inbound_instruction;
                end else if (is_shift || is_mul) begin
                    cnt_d       = is_mul ? 6'd32 : {1'b0, reg_right_data[4:0]};
                    acc_d       = is_mul ? '0 : reg_left_data;
                    mcand_d     = reg_left_data;
                    mplier_d    = reg_right_data;
                    lat_instr_d = inbound_instruction;
                    lat_dest_d  = inbound_instruction[DEST_HI:DEST_LO];
                end else begin
                    outbound_d  = inbound_instruction;
                end
            end
            SHIFT: begin
                cnt_d = cnt - 6'd1;
                acc_d = shift_next;
                if (last) begin
                    write_d       = 1'b1;
                    write_index_d = lat_dest;
                    write_data_d  = shift_next;
                    flags_d       = result_flags(shift_next, shift_c, 1'b0);
                    outbound_d    = lat_instr;
                end
            end
            default: begin
                cnt_d    = cnt - 6'd1;
                acc_d    = mul_next;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                if (last) begin
                    write_d       = 1'b1;
                    write_index_d = lat_dest;
                    write_data_d  = mul_next;
                    flags_d       = result_flags(mul_next, 1'b0, 1'b0);
                    outbound_d    = lat_instr;
                end
            end
        endcase
    end

    // register the datapath and outputs; reset returns everything to a NOP state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt                  <= '0;
            acc                  <= '0;
            mcand                <= '0;
            mplier               <= '0;
            lat_instr            <= '0;
            lat_dest             <= '0;
            write                <= 1'b0;
            write_index          <= '0;
            write_data           <= '0;
            flags                <= '0;
            outbound_instruction <= '0;
        end else begin
            cnt                  <= cnt_d;
            acc                  <= acc_d;
            mcand                <= mcand_d;
            mplier               <= mplier_d;
            lat_instr            <= lat_instr_d;
            lat_dest             <= lat_dest_d;
            write                <= write_d;
            write_index          <= write_index_d;
            write_data           <= write_data_d;
            flags                <= flags_d;
            outbound_instruction <= outbound_d;
        end
    end

endmodule
